// File: rtl/keypad_event_encoder.sv
// Keypad front end: synchronises and debounces raw key lines, turns each fresh press into a
// priority-encoded event and queues it for the calculator control FSM.
module keypad_event_encoder #(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_OP_KEYS     = 2,
  parameter int CODE_W          = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [CODE_W-1:0]   out,
  output logic                is_op,
  output logic                is_result,
  output logic                is_enter,
  output logic                overflow
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = CODE_W + 3;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ACC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] sync0_q, sync0_d, sync1_q, sync1_d, db_q, db_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  mem_d [FIFO_DEPTH];

  logic               accept, press, full, push, pop;
  logic [CODE_W-1:0]  idx;
  logic [ENTRY_W-1:0] entry, head;

  // Synchroniser and debounce: a vector is accepted once it has held for DEBOUNCE_CYCLES.
  always_comb begin
    sync0_d = in;
    sync1_d = sync0_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    accept  = (sync0_q == sync1_q) && (cnt_q == CNT_ACC);
    if (sync0_q != sync1_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (accept) begin
      db_d = sync1_q;
    end
    // Only a transition out of the all-released state counts as a press.
    press = accept && (db_q == '0) && (sync1_q != '0);
  end

  // Lowest set key wins; the loop runs high-to-low so the last hit is the lowest index.
  always_comb begin
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (sync1_q[i]) idx = CODE_W'(i);
    end
    entry = {idx + CODE_W'(1), idx < CODE_W'(NUM_OP_KEYS), idx < CODE_W'(NUM_OP_KEYS),
             idx == CODE_W'(NUM_KEYS - 1)};
  end

  // Handshake: an event transfers on every rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and out_ready is ignored while out_valid is low.
  always_comb begin
    full       = (count_q == FIFO_FULL);
    pop        = out_valid && out_ready;
    push       = press && (!full || pop);
    overflow_d = overflow_q || (press && full && !pop);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + FCNT_W'(1);
    else if (pop && !push) count_d = count_q - FCNT_W'(1);
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = entry;
  end

  always_comb begin
    out_valid = (count_q != '0);
    head      = out_valid ? mem_q[rd_ptr_q] : '0;
    out       = head[ENTRY_W-1:3];
    is_op     = head[2];
    is_result = head[1];
    is_enter  = head[0];
    overflow  = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q    <= '0;
      sync1_q    <= '0;
      db_q       <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync0_q    <= sync0_d;
      sync1_q    <= sync1_d;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed bench for keypad_event_encoder: stimulus pushes expected events into a queue,
// a negedge monitor pops and compares every event the DUT hands over.
module tb_keypad_event_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_r;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out;
  logic       is_op, is_result, is_enter, overflow;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  keypad_event_encoder dut (
    .clk(clk), .rst(rst), .in(in_r), .out_ready(out_ready), .out_valid(out_valid),
    .out(out), .is_op(is_op), .is_result(is_result), .is_enter(is_enter),
    .overflow(overflow)
  );

  // Clock and watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entry packing: {code, is_op, is_result, is_enter}
  function automatic logic [5:0] ev(input logic [2:0] code, input logic op, input logic enter);
    return {code, op, op, enter};
  endfunction

  // Monitor: every transferred event must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {26'd0, out, is_op, is_result, is_enter}, 32'hdead);
      end else begin
        check("event", {26'd0, out, is_op, is_result, is_enter}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input logic [3:0] v);
    in_r = v;
    cycles(10);
    in_r = 4'b0000;
    cycles(10);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_r = 4'b1111;
    cycles(2);
    sample();
    check("reset_outputs", {25'd0, out_valid, out, is_op, is_result, is_enter, overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_r = 4'b0000;
  endtask

  initial begin
    out_ready = 1'b0;
    do_reset();
    cycles(12);
    sample();
    check("reset_no_event", {31'd0, out_valid}, 32'd0);

    // Clean press of key 0: written at edge 6, visible after it.
    @(posedge clk);
    #1;
    in_r = 4'b0001;
    exp_q.push_back(ev(3'd1, 1'b1, 1'b0));
    cycles(5);
    sample();
    check("latency_not_before_e6", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    sample();
    check("latency_after_e6", {31'd0, out_valid}, 32'd1);
    check("press_head", {26'd0, out, is_op, is_result, is_enter}, {26'd0, ev(3'd1, 1'b1, 1'b0)});
    cycles(3);
    sample();
    check("held_while_not_ready", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycles(1);
    sample();
    check("popped_empty", {31'd0, out_valid}, 32'd0);
    check("idle_outputs_zero", {28'd0, out, is_op}, 32'd0);
    in_r = 4'b0000;
    cycles(10);

    // Bounce: never stable long enough, so nothing is queued.
    for (int i = 0; i < 10; i++) begin
      in_r = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      cycles(2);
    end
    in_r = 4'b0000;
    cycles(12);
    sample();
    check("bounce_no_event", {31'd0, out_valid}, 32'd0);
    exp_q.push_back(ev(3'd4, 1'b0, 1'b1));
    press_release(4'b1000);
    check("enter_drained", exp_q.size(), 32'd0);

    // Priority encode, then a held change without release yields nothing.
    exp_q.push_back(ev(3'd2, 1'b1, 1'b0));
    in_r = 4'b0110;
    cycles(10);
    in_r = 4'b0100;
    cycles(10);
    in_r = 4'b0000;
    cycles(10);
    check("priority_single_event", exp_q.size(), 32'd0);

    // Overflow: five presses into a four-deep queue.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(ev(3'd3, 1'b0, 1'b0));
      press_release(4'b0100);
    end
    sample();
    check("overflow_set", {30'd0, overflow, out_valid}, 32'd3);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycles(8);
    sample();
    check("overflow_drained", {30'd0, overflow, out_valid}, 32'd2);
    check("overflow_exp_empty", exp_q.size(), 32'd0);
    out_ready = 1'b0;
    do_reset();
    cycles(1);
    sample();
    check("overflow_cleared_by_reset", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    cycles(10);

    // Full queue with a pop on the same edge as the push: nothing dropped.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ev(3'd3, 1'b0, 1'b0));
      press_release(4'b0100);
    end
    exp_q.push_back(ev(3'd4, 1'b0, 1'b1));
    in_r = 4'b1000;
    cycles(5);
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    sample();
    check("full_pop_push_no_overflow", {30'd0, overflow, out_valid}, 32'd1);
    check("full_pop_push_remaining", exp_q.size(), 32'd4);
    in_r = 4'b0000;
    cycles(10);
    out_ready = 1'b1;
    cycles(8);
    sample();
    check("full_pop_push_drained", {30'd0, overflow, out_valid}, 32'd0);
    check("final_exp_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
